// File: rtl/fdtd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdtd_pkg
// Description : Shared types and constants for the FDTD buffer write-back
//               path: job kinds, write-back FSM states and the data_mem word
//               size in bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package fdtd_pkg;

    // Job kinds; the encoding is visible on wb_type_o.
    typedef enum logic [1:0] {
        WB_HY  = 2'd0,
        WB_EZ  = 2'd1,
        WB_SRC = 2'd2
    } wb_job_e;

    // Write-back FSM states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } wb_state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

endpackage : fdtd_pkg
`default_nettype wire

// File: rtl/fdtd_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : fdtd_edge_det
// Description : Rising-edge detector for the three write-back start levels
//               with fixed priority Hy > Ez > src. Losing edges are simply
//               not reported.
// Ports       : CLK, RST_N   - clock, asynchronous active-low reset
//               i_level[2:0] - {src, Ez, Hy} start levels
//               o_start[2:0] - one-hot winning edge (same bit order)
//               o_any        - any rising edge this cycle
//               o_job        - job kind of the winning edge
// Revision    : 1.0 - initial release
// ============================================================================
module fdtd_edge_det
    import fdtd_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  i_level,
    output logic [2:0]  o_start,
    output logic        o_any,
    output wb_job_e     o_job
);

    logic [2:0] r_level_q;
    logic [2:0] w_rise;

    // History is tracked every cycle, so an edge that is not accepted when
    // it occurs is gone for good.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_level_q <= '0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign w_rise = i_level & ~r_level_q;
    assign o_any  = |w_rise;

    always_comb begin
        o_start = 3'b000;
        o_job   = WB_HY;
        if (w_rise[0]) begin
            o_start = 3'b001;
            o_job   = WB_HY;
        end else if (w_rise[1]) begin
            o_start = 3'b010;
            o_job   = WB_EZ;
        end else if (w_rise[2]) begin
            o_start = 3'b100;
            o_job   = WB_SRC;
        end
    end

endmodule : fdtd_edge_det
`default_nettype wire

// File: rtl/fdtd_buf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : fdtd_buf_writeback
// Description : Copies a finished Hy or Ez line (or a single Ez source
//               sample) from the ram_buffer into data_mem through a req/gnt
//               write master. One word per RD -> CAP -> WR pass.
// Ports       : CLK, RST_N                 - clock, async active-low reset
//               buffer_size_i              - samples per line (clamped)
//               hy/ez_base_addr_i          - byte address of Hy[0] / Ez[0]
//               src_idx_i                  - Ez index for a src job
//               wrt_{Hy,Ez,src}_start_i    - start levels (rising edge)
//               buf_rd_en/sel/addr_o       - ram_buffer read port
//               buf_{Hy,Ez}_rdata_i        - read data, 1 cycle latency
//               data_req/we/be/addr/wdata_o, data_gnt_i - data_mem master
//               wb_busy_o, wb_done_o, wb_type_o         - job status
// Revision    : 1.0 - initial release
// ============================================================================
module fdtd_buf_writeback
    import fdtd_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int FDTD_DATA_WIDTH   = 16,
    parameter int BUFFER_SIZE       = 50,
    parameter int MEM_ADDR_WIDTH    = 32,
    parameter int MEM_DATA_WIDTH    = 32
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [FDTD_DATA_WIDTH-1:0]    buffer_size_i,
    input  logic [MEM_ADDR_WIDTH-1:0]     hy_base_addr_i,
    input  logic [MEM_ADDR_WIDTH-1:0]     ez_base_addr_i,
    input  logic [BUFFER_ADDR_WIDTH-1:0]  src_idx_i,
    input  logic                          wrt_Hy_start_i,
    input  logic                          wrt_Ez_start_i,
    input  logic                          wrt_src_start_i,
    output logic                          buf_rd_en_o,
    output logic                          buf_rd_sel_o,
    output logic [BUFFER_ADDR_WIDTH-1:0]  buf_rd_addr_o,
    input  logic [FDTD_DATA_WIDTH-1:0]    buf_Hy_rdata_i,
    input  logic [FDTD_DATA_WIDTH-1:0]    buf_Ez_rdata_i,
    output logic                          data_req_o,
    input  logic                          data_gnt_i,
    output logic                          data_we_o,
    output logic [3:0]                    data_be_o,
    output logic [MEM_ADDR_WIDTH-1:0]     data_addr_o,
    output logic [MEM_DATA_WIDTH-1:0]     data_wdata_o,
    output logic                          wb_busy_o,
    output logic                          wb_done_o,
    output logic [1:0]                    wb_type_o
);

    localparam int c_cnt_w = $clog2(BUFFER_SIZE + 1);
    localparam int c_ext_w = MEM_DATA_WIDTH - FDTD_DATA_WIDTH;
    localparam logic [c_cnt_w-1:0]           c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]           c_n_max   = c_cnt_w'(BUFFER_SIZE);
    localparam logic [BUFFER_ADDR_WIDTH-1:0] c_idx_one = BUFFER_ADDR_WIDTH'(1);
    localparam logic [BUFFER_ADDR_WIDTH-1:0] c_idx_max = BUFFER_ADDR_WIDTH'(BUFFER_SIZE - 1);
    localparam logic [FDTD_DATA_WIDTH-1:0]   c_size_max = FDTD_DATA_WIDTH'(BUFFER_SIZE);

    wb_state_e                   r_state;
    wb_state_e                   w_next;
    wb_job_e                     r_job;
    logic [MEM_ADDR_WIDTH-1:0]   r_base;
    logic [c_cnt_w-1:0]          r_n;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [BUFFER_ADDR_WIDTH-1:0] r_idx;
    logic [MEM_DATA_WIDTH-1:0]   r_wdata;

    logic [2:0]                  w_start;
    logic                        w_start_any;
    wb_job_e                     w_job;
    logic                        w_accept;
    logic [c_cnt_w-1:0]          w_n_len;
    logic [BUFFER_ADDR_WIDTH-1:0] w_src_idx;
    logic                        w_last;
    logic [FDTD_DATA_WIDTH-1:0]  w_rdata_sel;
    logic [MEM_ADDR_WIDTH-1:0]   w_offset;
    logic [MEM_ADDR_WIDTH-1:0]   w_wr_addr;

    fdtd_edge_det u_edge_det (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_level ({wrt_src_start_i, wrt_Ez_start_i, wrt_Hy_start_i}),
        .o_start (w_start),
        .o_any   (w_start_any),
        .o_job   (w_job)
    );

    assign w_accept = (r_state == IDLE) && w_start_any;

    // Line length for the winning job: src jobs always move one sample.
    always_comb begin
        w_n_len = '0;
        if (w_start[2]) begin
            w_n_len = c_cnt_one;
        end else if (buffer_size_i > c_size_max) begin
            w_n_len = c_n_max;
        end else begin
            w_n_len = buffer_size_i[c_cnt_w-1:0];
        end
    end

    // Keeps the read index inside the physical line even for a bad src_idx.
    assign w_src_idx = (src_idx_i > c_idx_max) ? c_idx_max : src_idx_i;

    // Word count is kept apart from the buffer index because a src job
    // starts at a non-zero index but still writes only one word.
    assign w_last      = (r_cnt + c_cnt_one) == r_n;
    assign w_rdata_sel = (r_job == WB_HY) ? buf_Hy_rdata_i : buf_Ez_rdata_i;
    assign w_offset    = {{(MEM_ADDR_WIDTH - BUFFER_ADDR_WIDTH){1'b0}}, r_idx} << WORD_SHIFT;
    assign w_wr_addr   = r_base + w_offset;

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_n_len == '0) ? DONE : RD;
                end
            end
            RD:   w_next = CAP;
            CAP:  w_next = WR;
            WR: begin
                if (data_gnt_i) begin
                    w_next = w_last ? DONE : RD;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_job   <= WB_HY;
            r_base  <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_job  <= w_job;
                r_base <= w_start[0] ? hy_base_addr_i : ez_base_addr_i;
                r_n    <= w_n_len;
                r_cnt  <= '0;
                r_idx  <= w_start[2] ? w_src_idx : '0;
            end
            if (r_state == CAP) begin
                r_wdata <= {{c_ext_w{w_rdata_sel[FDTD_DATA_WIDTH-1]}}, w_rdata_sel};
            end
            if ((r_state == WR) && data_gnt_i && !w_last) begin
                r_idx <= r_idx + c_idx_one;
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    // Everything is decoded from the state so that an asynchronous reset
    // clears every output in the same cycle, including an open request.
    always_comb begin
        buf_rd_en_o   = 1'b0;
        buf_rd_sel_o  = 1'b0;
        buf_rd_addr_o = '0;
        data_req_o    = 1'b0;
        data_we_o     = 1'b0;
        data_be_o     = 4'b0000;
        data_addr_o   = '0;
        data_wdata_o  = '0;
        wb_busy_o     = (r_state != IDLE);
        wb_done_o     = 1'b0;
        case (r_state)
            RD: begin
                buf_rd_en_o   = 1'b1;
                buf_rd_sel_o  = (r_job != WB_HY);
                buf_rd_addr_o = r_idx;
            end
            WR: begin
                data_req_o   = 1'b1;
                data_we_o    = 1'b1;
                data_be_o    = 4'b1111;
                data_addr_o  = w_wr_addr;
                data_wdata_o = r_wdata;
            end
            DONE:    wb_done_o = 1'b1;
            default: ;
        endcase
    end

    assign wb_type_o = r_job;

endmodule : fdtd_buf_writeback
`default_nettype wire

// File: tb/tb_fdtd_buf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_fdtd_buf_writeback
// Description : Self-checking bench for fdtd_buf_writeback. A ram_buffer
//               model and a grant driver surround the DUT; a monitor
//               collects completed writes and the expected write list of
//               every job is computed from the line length, base addresses
//               and buffer contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdtd_buf_writeback;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int BS = 50;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] buffer_size_i = '0;
    logic [31:0] hy_base_addr_i = '0;
    logic [31:0] ez_base_addr_i = '0;
    logic [5:0]  src_idx_i = '0;
    logic        wrt_Hy_start_i = 1'b0;
    logic        wrt_Ez_start_i = 1'b0;
    logic        wrt_src_start_i = 1'b0;
    logic        buf_rd_en_o;
    logic        buf_rd_sel_o;
    logic [5:0]  buf_rd_addr_o;
    logic [15:0] buf_Hy_rdata_i = '0;
    logic [15:0] buf_Ez_rdata_i = '0;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        wb_busy_o;
    logic        wb_done_o;
    logic [1:0]  wb_type_o;

    always #5 CLK = ~CLK;

    fdtd_buf_writeback #(
        .BUFFER_ADDR_WIDTH (AW),
        .FDTD_DATA_WIDTH   (DW),
        .BUFFER_SIZE       (BS),
        .MEM_ADDR_WIDTH    (32),
        .MEM_DATA_WIDTH    (32)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .buffer_size_i   (buffer_size_i),
        .hy_base_addr_i  (hy_base_addr_i),
        .ez_base_addr_i  (ez_base_addr_i),
        .src_idx_i       (src_idx_i),
        .wrt_Hy_start_i  (wrt_Hy_start_i),
        .wrt_Ez_start_i  (wrt_Ez_start_i),
        .wrt_src_start_i (wrt_src_start_i),
        .buf_rd_en_o     (buf_rd_en_o),
        .buf_rd_sel_o    (buf_rd_sel_o),
        .buf_rd_addr_o   (buf_rd_addr_o),
        .buf_Hy_rdata_i  (buf_Hy_rdata_i),
        .buf_Ez_rdata_i  (buf_Ez_rdata_i),
        .data_req_o      (data_req_o),
        .data_gnt_i      (data_gnt_i),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .wb_busy_o       (wb_busy_o),
        .wb_done_o       (wb_done_o),
        .wb_type_o       (wb_type_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------- ram_buffer model
    // Data is only meaningful the cycle after a read; otherwise it is junk.
    logic [15:0] hy_mem [64];
    logic [15:0] ez_mem [64];

    always @(posedge CLK) begin
        if (buf_rd_en_o) begin
            buf_Hy_rdata_i <= hy_mem[buf_rd_addr_o];
            buf_Ez_rdata_i <= ez_mem[buf_rd_addr_o];
        end else begin
            buf_Hy_rdata_i <= 16'($urandom);
            buf_Ez_rdata_i <= 16'($urandom);
        end
    end

    // --------------------------------------------------------- grant driver
    // 0: always granted, 1: random stalls, 2: 5-cycle stall on word 2, 3: never
    int gnt_mode  = 0;
    int stall_cnt = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wr_q[$];

    always @(posedge CLK) begin
        #1;
        case (gnt_mode)
            0: data_gnt_i = 1'b1;
            1: data_gnt_i = ($urandom_range(0, 2) != 0);
            2: begin
                if (data_req_o && wr_q.size() == 1 && stall_cnt < 5) begin
                    data_gnt_i = 1'b0;
                    stall_cnt++;
                end else begin
                    data_gnt_i = 1'b1;
                end
            end
            default: data_gnt_i = 1'b0;
        endcase
    end

    // -------------------------------------------------------------- monitor
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          rd_cnt   = 0;
    int          sel1_cnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_req = 1'b0;
            prev_gnt = 1'b0;
        end else begin
            if (wb_done_o) done_cnt++;
            if (wb_busy_o) busy_cnt++;
            if (buf_rd_en_o) begin
                rd_cnt++;
                if (buf_rd_sel_o) sel1_cnt++;
            end
            if (prev_req && !prev_gnt) begin
                chk("req_held", data_req_o, 1);
                chk("addr_stable", data_addr_o, prev_addr);
                chk("wdata_stable", data_wdata_o, prev_wdata);
            end
            if (data_req_o) begin
                chk("we", data_we_o, 1);
                chk("be", data_be_o, 4'hF);
            end
            if (data_req_o && data_gnt_i) wr_q.push_back({data_addr_o, data_wdata_o});
            prev_req   = data_req_o;
            prev_gnt   = data_gnt_i;
            prev_addr  = data_addr_o;
            prev_wdata = data_wdata_o;
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, buf_rd_en_o, 0);
        chk({tag, "_rd_sel"}, buf_rd_sel_o, 0);
        chk({tag, "_rd_addr"}, buf_rd_addr_o, 0);
        chk({tag, "_req"}, data_req_o, 0);
        chk({tag, "_we"}, data_we_o, 0);
        chk({tag, "_be"}, data_be_o, 0);
        chk({tag, "_addr"}, data_addr_o, 0);
        chk({tag, "_wdata"}, data_wdata_o, 0);
        chk({tag, "_busy"}, wb_busy_o, 0);
        chk({tag, "_done"}, wb_done_o, 0);
        chk({tag, "_type"}, wb_type_o, 0);
    endtask

    // kind: 0 Hy, 1 Ez, 2 src; mask: levels raised together {src,Ez,Hy};
    // poke: re-raise Ez while the job is busy.
    task automatic run_job(input int kind, input logic [2:0] mask, input int bsize,
                           input int sidx, input int mode, input bit poke, input string tag);
        int          n;
        int          idx;
        logic [31:0] base;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        logic [15:0] s;
        bit          got;
        wr_q.delete();
        done_cnt  = 0;
        busy_cnt  = 0;
        rd_cnt    = 0;
        sel1_cnt  = 0;
        stall_cnt = 0;
        gnt_mode  = mode;
        buffer_size_i = 16'(bsize);
        src_idx_i     = 6'(sidx);
        @(posedge CLK); #1;
        {wrt_src_start_i, wrt_Ez_start_i, wrt_Hy_start_i} = mask;
        @(posedge CLK); #1;
        {wrt_src_start_i, wrt_Ez_start_i, wrt_Hy_start_i} = 3'b000;
        if (poke) begin
            repeat (3) @(posedge CLK);
            #1 wrt_Ez_start_i = 1'b1;
            @(posedge CLK);
            #1 wrt_Ez_start_i = 1'b0;
        end
        got = 1'b0;
        for (int t = 0; t < 1000 && !got; t++) begin
            @(negedge CLK);
            if (wb_done_o) got = 1'b1;
        end
        chk({tag, "_done_seen"}, got, 1);
        repeat (20) @(negedge CLK);

        n    = (kind == 2) ? 1 : ((bsize < BS) ? bsize : BS);
        base = (kind == 0) ? hy_base_addr_i : ez_base_addr_i;
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_end"}, wb_busy_o, 0);
        chk({tag, "_type"}, wb_type_o, kind);
        chk({tag, "_nwrites"}, wr_q.size(), n);
        chk({tag, "_nreads"}, rd_cnt, n);
        chk({tag, "_sel_ez"}, sel1_cnt, (kind == 0) ? 0 : n);
        if (mode == 0) chk({tag, "_busy_cycles"}, busy_cnt, 3 * n + 1);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            idx   = (kind == 2) ? sidx : i;
            s     = (kind == 0) ? hy_mem[idx] : ez_mem[idx];
            exp_d = {{16{s[15]}}, s};
            exp_a = base + 32'(idx * 4);
            chk({tag, "_addr"}, wr_q[i].a, exp_a);
            chk({tag, "_data"}, wr_q[i].d, exp_d);
        end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        bit got;
        for (int i = 0; i < 64; i++) begin
            hy_mem[i] = 16'($urandom);
            ez_mem[i] = 16'($urandom);
        end
        hy_mem[1] = 16'h8001;
        ez_mem[7] = 16'hFFF0;

        repeat (3) @(posedge CLK);
        chk_zero("reset");
        #1 RST_N = 1'b1;

        // Hy line, grant tied high
        hy_base_addr_i = 32'h1000;
        run_job(0, 3'b001, 4, 0, 0, 1'b0, "hy4");

        // Ez line with a 5-cycle stall on the second word
        ez_base_addr_i = 32'h3000;
        run_job(1, 3'b010, 3, 0, 2, 1'b0, "ez3_stall");
        chk("ez3_stall_len", stall_cnt, 5);

        // src job: single Ez sample
        ez_base_addr_i = 32'h2000;
        run_job(2, 3'b100, 9, 7, 0, 1'b0, "src7");
        if (wr_q.size() > 0) begin
            chk("src7_addr_fixed", wr_q[0].a, 32'h201C);
            chk("src7_data_fixed", wr_q[0].d, 32'hFFFF_FFF0);
        end

        // Hy+Ez together, then an Ez edge while busy: only Hy runs
        hy_base_addr_i = 32'h1000;
        run_job(0, 3'b011, 4, 0, 0, 1'b1, "hy_ez_prio");

        // Empty line and over-long line
        run_job(0, 3'b001, 0, 0, 0, 1'b0, "size0");
        run_job(1, 3'b010, 200, 0, 0, 1'b0, "size200");

        // Reset while a request is outstanding
        wr_q.delete();
        done_cnt = 0;
        gnt_mode = 3;
        buffer_size_i = 16'd10;
        @(posedge CLK); #1 wrt_Hy_start_i = 1'b1;
        @(posedge CLK); #1 wrt_Hy_start_i = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge CLK);
            if (data_req_o) got = 1'b1;
        end
        chk("rst_req_seen", got, 1);
        #1 RST_N = 1'b0;
        #1 chk_zero("rst_mid");
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        chk("rst_no_done", done_cnt, 0);
        chk("rst_no_write", wr_q.size(), 0);
        hy_base_addr_i = 32'h1000;
        run_job(0, 3'b001, 3, 0, 0, 1'b0, "after_rst");

        // Randomized jobs, random grant stalls, bases near the wrap point
        for (int j = 0; j < 6; j++) begin
            int k;
            k = $urandom_range(0, 2);
            hy_base_addr_i = (j % 2 == 0) ? 32'hFFFF_FF80 + 32'($urandom_range(0, 31)) * 4
                                          : $urandom & 32'hFFFF_FFFC;
            ez_base_addr_i = $urandom & 32'hFFFF_FFFC;
            run_job(k, 3'(1 << k), $urandom_range(0, 60), $urandom_range(0, BS - 1),
                    1, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fdtd_buf_writeback
`default_nettype wire
